// File: rtl/conv_scheduler.sv
// Sequences one image through an external convolver once per filter and streams results to an output buffer.
// Per filter: 1 clear + INPUT_SIZE^2 reads + 2 drain cycles; reads stall on !out_ready, writes never stall.
module conv_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int INPUT_SIZE  = 28,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_FILTERS = 4
) (
    input  logic                                   clk,
    input  logic                                   global_rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic [$clog2(INPUT_SIZE*INPUT_SIZE)-1:0] in_addr,
    output logic                                   in_rd_en,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    output logic [((NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1)-1:0] w_sel,
    output logic                                   conv_rst,
    output logic                                   conv_ce,
    output logic [DATA_WIDTH-1:0]                  conv_in,
    input  logic [DATA_WIDTH-1:0]                  conv_op,
    input  logic                                   conv_valid,
    input  logic                                   out_ready,
    output logic                                   out_wr_en,
    output logic [$clog2(NUM_FILTERS*(INPUT_SIZE-KERNEL_SIZE+1)*(INPUT_SIZE-KERNEL_SIZE+1))-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]                  out_data
);

    localparam int OUT_SIZE = INPUT_SIZE - KERNEL_SIZE + 1;
    localparam int IN_PIX   = INPUT_SIZE * INPUT_SIZE;
    localparam int OUT_PIX  = OUT_SIZE * OUT_SIZE;
    localparam int AW       = $clog2(IN_PIX);
    localparam int FW       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int OAW      = $clog2(NUM_FILTERS * OUT_PIX);
    localparam int CW       = $clog2(OUT_PIX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [FW-1:0]   filter_q;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   wr_cnt_inc;
    logic            drain_cnt;
    logic            conv_ce_q;
    logic            ce_d_q;
    logic            err_q;
    logic            rd_en;
    logic            clr;
    logic            dn;
    logic            last_read;
    logic            last_filter;

    assign last_read   = (in_addr == AW'(IN_PIX - 1));
    assign last_filter = (filter_q == FW'(NUM_FILTERS - 1));

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        clr       = 1'b0;
        dn        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                clr       = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                rd_en = out_ready;
                if (out_ready && last_read) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) state_nxt = last_filter ? DONE : CLEAR;
            end
            DONE: begin
                dn        = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are masked during reset so an in-flight read or write is dropped in the reset cycle itself.
    assign in_rd_en   = rd_en & ~global_rst;
    assign done       = dn & ~global_rst;
    assign conv_rst   = clr | global_rst;
    assign busy       = (state != IDLE);
    assign err        = err_q;
    assign w_sel      = filter_q;
    assign conv_ce    = conv_ce_q;
    assign conv_in    = in_data;
    assign out_wr_en  = ce_d_q & conv_valid & ~global_rst;
    assign out_data   = conv_op;
    assign out_addr   = OAW'(32'(filter_q) * 32'(OUT_PIX) + 32'(wr_cnt));
    assign wr_cnt_inc = wr_cnt + CW'(out_wr_en);

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state     <= IDLE;
            in_addr   <= '0;
            filter_q  <= '0;
            wr_cnt    <= '0;
            drain_cnt <= 1'b0;
            conv_ce_q <= 1'b0;
            ce_d_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            conv_ce_q <= in_rd_en;
            ce_d_q    <= conv_ce_q;
            wr_cnt    <= wr_cnt_inc;
            case (state)
                IDLE: begin
                    if (start) begin
                        filter_q <= '0;
                        err_q    <= 1'b0;
                        wr_cnt   <= '0;
                        in_addr  <= '0;
                    end
                end
                CLEAR: begin
                    in_addr   <= '0;
                    drain_cnt <= 1'b0;
                end
                STREAM: begin
                    if (in_rd_en) in_addr <= last_read ? '0 : in_addr + AW'(1);
                end
                DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    // The count includes a write landing in this very cycle.
                    if (drain_cnt) begin
                        if (wr_cnt_inc != CW'(OUT_PIX)) err_q <= 1'b1;
                        if (!last_filter) begin
                            filter_q <= filter_q + FW'(1);
                            wr_cnt   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler with a behavioural 3x3 convolver and image memory attached.
module tb_conv_scheduler;

    localparam int DW   = 8;
    localparam int IS   = 4;
    localparam int KS   = 3;
    localparam int NF   = 2;
    localparam int IPIX = IS * IS;

    logic          clk = 1'b0;
    logic          global_rst;
    logic          start;
    logic          busy, done, err;
    logic [3:0]    in_addr;
    logic          in_rd_en;
    logic [DW-1:0] in_data = '0;
    logic [0:0]    w_sel;
    logic          conv_rst, conv_ce;
    logic [DW-1:0] conv_in, conv_op;
    logic          conv_valid;
    logic          out_ready;
    logic          out_wr_en;
    logic [2:0]    out_addr;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    conv_scheduler #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .KERNEL_SIZE(KS), .NUM_FILTERS(NF)) dut (
        .clk(clk), .global_rst(global_rst), .start(start), .busy(busy), .done(done), .err(err),
        .in_addr(in_addr), .in_rd_en(in_rd_en), .in_data(in_data), .w_sel(w_sel),
        .conv_rst(conv_rst), .conv_ce(conv_ce), .conv_in(conv_in), .conv_op(conv_op),
        .conv_valid(conv_valid), .out_ready(out_ready), .out_wr_en(out_wr_en),
        .out_addr(out_addr), .out_data(out_data)
    );

    // Image memory (1-cycle read latency) and convolver model: weights 1, bias 0.
    logic [DW-1:0] img [IPIX];
    logic [DW-1:0] pix_buf [IPIX];
    int            pix_cnt = 0;
    logic          model_valid = 1'b0;
    logic [DW-1:0] model_op = '0;
    logic          kill_valid = 1'b0;

    always @(posedge clk) if (in_rd_en) in_data <= img[in_addr];

    function automatic logic win_ok(input int p);
        return (p < IPIX) && (p / IS >= KS - 1) && (p % IS >= KS - 1);
    endfunction

    function automatic logic [DW-1:0] win_sum(input int p, input logic [DW-1:0] v);
        int s = 0;
        int idx;
        for (int i = 0; i < KS; i++)
            for (int j = 0; j < KS; j++) begin
                idx = (p / IS - i) * IS + (p % IS - j);
                if (idx == p) s += int'(v);
                else if (idx >= 0 && idx < IPIX) s += int'(pix_buf[idx]);
            end
        return s[DW-1:0];
    endfunction

    always @(posedge clk) begin
        if (conv_rst) begin
            pix_cnt     <= 0;
            model_valid <= 1'b0;
            model_op    <= '0;
        end else if (conv_ce) begin
            if (pix_cnt < IPIX) pix_buf[pix_cnt] <= conv_in;
            pix_cnt     <= pix_cnt + 1;
            model_valid <= win_ok(pix_cnt);
            model_op    <= win_sum(pix_cnt, conv_in);
        end
    end

    assign conv_valid = model_valid & ~(kill_valid & (w_sel == 1'b0));
    assign conv_op    = model_op;

    // Cycle counter and output monitor.
    int         cyc = 0, base = 0;
    int         done_cnt = 0, done_at = -1, ce_cnt = 0, gap_ce = 0;
    logic       bp_mode = 1'b0;
    logic [2:0] wa [$];
    logic [7:0] wd [$];
    logic       ws [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_wr_en) begin
            wa.push_back(out_addr);
            wd.push_back(out_data);
            ws.push_back(w_sel[0]);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc - base;
        end
        if (conv_ce) begin
            ce_cnt <= ce_cnt + 1;
            if (bp_mode && (cyc - base) >= 7 && (cyc - base) <= 11) gap_ce <= gap_ce + 1;
        end
    end

    int n_checks = 0, n_fail = 0;
    int done_base, wr_base, ce_base;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic goto_pos(input int c);
        while (cyc - base < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run();
        @(posedge clk);
        #1;
        base      = cyc;
        done_base = done_cnt;
        wr_base   = wa.size();
        ce_base   = ce_cnt;
        start     = 1'b1;
        goto_pos(1);
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int exp_done, input int first, input int nwr,
                             input logic exp_err);
        int guard = 0;
        while (done_cnt == done_base && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt - done_base, 1);
        chk({tag, "_done_cyc"}, done_at, exp_done);
        chk({tag, "_nwr"}, wa.size() - wr_base, nwr);
        for (int i = 0; i < nwr && wr_base + i < wa.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wa[wr_base + i], first + i);
            chk($sformatf("%s_data%0d", tag, i), wd[wr_base + i], 9);
            chk($sformatf("%s_wsel%0d", tag, i), ws[wr_base + i], (first + i) / 4);
        end
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ce_cnt"}, ce_cnt - ce_base, 2 * IPIX);
    endtask

    initial begin
        int guard;
        int n_before;
        for (int i = 0; i < IPIX; i++) img[i] = 8'd1;
        global_rst = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b1;

        // Reset held for 3 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_conv_ce", conv_ce, 0);
        chk("rst_conv_rst", conv_rst, 1);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_w_sel", w_sel, 0);
        @(posedge clk);
        #1 global_rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_conv_rst", conv_rst, 0);

        // Nominal run.
        start_run();
        goto_pos(1);
        @(negedge clk);
        chk("nom_clear_conv_rst", conv_rst, 1);
        check_run("nom", 39, 0, 8, 1'b0);

        // Extra start pulses while busy are ignored.
        start_run();
        goto_pos(5);
        start = 1'b1;
        goto_pos(6);
        start = 1'b0;
        goto_pos(25);
        start = 1'b1;
        goto_pos(26);
        start = 1'b0;
        check_run("busy_start", 39, 0, 8, 1'b0);

        // Backpressure: out_ready low for cycles 6..10.
        bp_mode = 1'b1;
        start_run();
        goto_pos(6);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_addr_c6", in_addr, 4);
        chk("bp_rd_en_c6", in_rd_en, 0);
        goto_pos(10);
        @(negedge clk);
        chk("bp_addr_c10", in_addr, 4);
        goto_pos(11);
        out_ready = 1'b1;
        check_run("bp", 44, 0, 8, 1'b0);
        chk("bp_gap_ce", gap_ce, 0);
        bp_mode = 1'b0;

        // Filter 0 produces no valid windows.
        kill_valid = 1'b1;
        start_run();
        goto_pos(19);
        @(negedge clk);
        chk("mis_err_c19", err, 0);
        goto_pos(20);
        @(negedge clk);
        chk("mis_err_c20", err, 1);
        check_run("mis", 39, 4, 4, 1'b1);
        kill_valid = 1'b0;

        // Reset in the middle of filter 1, then a fresh run.
        start_run();
        goto_pos(1);
        @(negedge clk);
        chk("rm_err_cleared", err, 0);
        guard = 0;
        while (!(w_sel == 1'b1 && in_addr == 4'd7) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("rm_reached", guard < 100, 1);
        chk("rm_f0_writes", wa.size() - wr_base, 4);
        global_rst = 1'b1;
        n_before   = wa.size();
        @(negedge clk);
        chk("rm_wr_en", out_wr_en, 0);
        chk("rm_rd_en", in_rd_en, 0);
        @(posedge clk);
        #1 global_rst = 1'b0;
        @(negedge clk);
        chk("rm_idle_busy", busy, 0);
        chk("rm_in_addr", in_addr, 0);
        repeat (5) @(negedge clk);
        chk("rm_no_writes", wa.size() - n_before, 0);
        start_run();
        check_run("rm_rerun", 39, 0, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel, weight and result width.
REQ-002 SHALL have parameter INPUT_SIZE, default 28: square input feature-map side.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3: convolver kernel side; stride fixed at 1; OUT_SIZE = INPUT_SIZE-KERNEL_SIZE+1.
REQ-004 SHALL have parameter NUM_FILTERS, default 4: filters run back-to-back over one image.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port global_rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of the last filter.
REQ-010 SHALL have port err  output  1  sticky: a filter pass wrote a count other than OUT_SIZE^2; cleared by the next accepted start.
REQ-011 SHALL have port in_addr  output  clog2(INPUT_SIZE^2)  image memory read address, raster order.
REQ-012 SHALL have port in_rd_en  output  1  image read strobe; data returns exactly 1 cycle later.
REQ-013 SHALL have port in_data  input  DATA_WIDTH  image read data.
REQ-014 SHALL have port w_sel  output  clog2(NUM_FILTERS)  filter index to the weight/bias store; stable for a whole pass.
REQ-015 SHALL have port conv_rst  output  1  convolver reset.
REQ-016 SHALL have port conv_ce  output  1  convolver clock enable.
REQ-017 SHALL have port conv_in  output  DATA_WIDTH  convolver pixel input.
REQ-018 SHALL have port conv_op  input  DATA_WIDTH  convolver result.
REQ-019 SHALL have port conv_valid  input  1  convolver window-valid flag (registered, held while ce low).
REQ-020 SHALL have port out_ready  input  1  output buffer has room for at least 2 more writes.
REQ-021 SHALL have port out_wr_en  output  1  output buffer write strobe.
REQ-022 SHALL have port out_addr  output  clog2(NUM_FILTERS*OUT_SIZE^2)  output buffer address.
REQ-023 SHALL have port out_data  output  DATA_WIDTH  output buffer write data.

Function
REQ-024 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-025 IDLE with start=1 SHALL go to CLEAR with filter=0, err=0, write count=0; start in any other state SHALL be ignored.
REQ-026 CLEAR SHALL last 1 cycle with conv_rst=1, conv_ce=0, in_addr=0, and then go to STREAM.
REQ-027 STREAM SHALL set in_rd_en=out_ready and increment in_addr on each issued read; after read INPUT_SIZE^2-1 is issued it SHALL go to DRAIN.
REQ-028 While out_ready=0 in STREAM, no read SHALL be issued and in_addr SHALL hold.
REQ-029 conv_ce SHALL equal in_rd_en delayed 1 cycle; conv_in SHALL equal in_data combinationally.
REQ-030 With ce_d = conv_ce delayed 1 cycle, out_wr_en SHALL equal ce_d & conv_valid and out_data SHALL equal conv_op.
REQ-031 out_addr SHALL equal filter*OUT_SIZE^2 + write count; the write count SHALL increment on each write.
REQ-032 Writes SHALL continue regardless of out_ready (at most 2 in flight).
REQ-033 DRAIN SHALL last exactly 2 cycles so that the conv_ce and ce_d pipeline empties.
REQ-034 At DRAIN exit, err SHALL set if the write count is not OUT_SIZE^2.
REQ-035 At DRAIN exit, if filter < NUM_FILTERS-1, the block SHALL increment filter, zero the write count and go to CLEAR; otherwise it SHALL go to DONE.
REQ-036 DONE SHALL last 1 cycle with done=1 and then go to IDLE.
REQ-037 w_sel SHALL equal filter.
REQ-038 All counters SHALL be wide enough that no wrap occurs before their terminal value.
REQ-039 Cycle cost SHALL be, per filter with out_ready=1, 1+INPUT_SIZE^2+2 cycles, plus 1 for DONE.

Reset
REQ-040 global_rst SHALL force IDLE from any state, including mid-STREAM or mid-DRAIN, discarding in-flight reads and writes.
REQ-041 Reset values SHALL be: busy=0, done=0, err=0, in_rd_en=0, in_addr=0, conv_ce=0, conv_rst=1, out_wr_en=0, out_addr=0, w_sel=0; all internal counters and pipeline flags 0.
REQ-042 conv_rst SHALL be 0 in IDLE after reset releases.

Verification (INPUT_SIZE=4, KERNEL_SIZE=3, NUM_FILTERS=2, real convolver attached, image all 1, weights all 1, bias 0)
REQ-043 Reset check: hold global_rst 3 cycles -> all outputs at REQ-041 values; after release busy=0 and conv_rst=0.
REQ-044 Nominal run: start pulse at cycle 0 -> 8 writes, out_data=9 each, out_addr 0..7 in order, w_sel 0 then 1, done=1 exactly in cycle 39, err=0.
REQ-045 Backpressure: out_ready=0 for 5 cycles mid-STREAM of filter 0 -> in_addr held, no conv_ce in gap, same 8 writes and values, done in cycle 44.
REQ-046 Reset mid-operation: global_rst at in_addr=7 of filter 1 -> next cycle IDLE, no further writes; a new start gives a full nominal run.
REQ-047 Start while busy: extra start pulses at cycles 5 and 25 -> ignored; behaviour identical to REQ-044.
REQ-048 Count mismatch: force conv_valid=0 during filter 0 -> 0 writes for filter 0, err=1 from DRAIN exit onward, filter 1 still written at out_addr 4..7, done still pulses.
